regfile_write_arbiter: RTL

//  Shares the Register_bank single write port (WRITE_ENABLE/DESTINATION_REG/DATA_IN) between
//  the pipeline write-back stage (port A) and the multi-cycle mult/div/load unit (port B).

---
 rtl/regfile_write_arbiter_pkg.sv | 13 +
 rtl/regfile_write_arbiter_reg_scoreboard.sv | 50 +++++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, starvation limit and arbiter state codes for the register-file write arbiter.
package regfile_write_arbiter_pkg;

   localparam int WORD_LEN     = 32;
   localparam int REG_ADDR_LEN = 5;
   localparam int STARVE_LIMIT = 4;

   typedef enum logic {
      ARB_NORMAL  = 1'b0,
      ARB_FORCE_B = 1'b1
   } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_reg_scoreboard.sv
// Busy scoreboard for long-latency destinations: set on reserve, clear on write, set wins.
// Hazards are combinational from the busy vector; OVERLAP_ERR pulses the cycle after a re-reserve.
module regfile_write_arbiter_reg_scoreboard #(
   parameter int REG_ADDR_LEN = regfile_write_arbiter_pkg::REG_ADDR_LEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    set_vld,
   input  logic [REG_ADDR_LEN-1:0] set_reg,
   input  logic                    clr_vld,
   input  logic [REG_ADDR_LEN-1:0] clr_reg,
   input  logic [REG_ADDR_LEN-1:0] src1_reg,
   input  logic [REG_ADDR_LEN-1:0] src2_reg,
   output logic                    hazard1,
   output logic                    hazard2,
   output logic                    overlap_err
);

   localparam int NREG = 2 ** REG_ADDR_LEN;

   logic [NREG-1:0] busy_q, busy_d;
   logic            overlap_q, overlap_d;

   always_comb begin
      busy_d    = busy_q;
      overlap_d = 1'b0;
      if (clr_vld) busy_d[clr_reg] = 1'b0;
      if (set_vld && set_reg != '0) begin
         busy_d[set_reg] = 1'b1;
         overlap_d       = busy_q[set_reg];
      end
      // r0 is hardwired and can never carry a pending write
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q    <= '0;
         overlap_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         overlap_q <= overlap_d;
      end
   end

   assign hazard1     = busy_q[src1_reg];
   assign hazard2     = busy_q[src2_reg];
   assign overlap_err = overlap_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates WB (A, priority) and long-latency unit (B) onto the single register-bank write port.
// One-cycle registered write; B is forced through after STARVE_LIMIT blocked cycles, stalling A.
module regfile_write_arbiter #(
   parameter int WORD_LEN     = regfile_write_arbiter_pkg::WORD_LEN,
   parameter int REG_ADDR_LEN = regfile_write_arbiter_pkg::REG_ADDR_LEN,
   parameter int STARVE_LIMIT = regfile_write_arbiter_pkg::STARVE_LIMIT
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    A_VALID,
   input  logic [REG_ADDR_LEN-1:0] A_REG,
   input  logic [WORD_LEN-1:0]     A_DATA,
   output logic                    A_READY,
   input  logic                    B_VALID,
   input  logic [REG_ADDR_LEN-1:0] B_REG,
   input  logic [WORD_LEN-1:0]     B_DATA,
   output logic                    B_READY,
   input  logic                    RSV_VALID,
   input  logic [REG_ADDR_LEN-1:0] RSV_REG,
   input  logic [REG_ADDR_LEN-1:0] SOURCE_REG1,
   input  logic [REG_ADDR_LEN-1:0] SOURCE_REG2,
   output logic                    HAZARD1,
   output logic                    HAZARD2,
   output logic                    OVERLAP_ERR,
   output logic                    WRITE_ENABLE,
   output logic [REG_ADDR_LEN-1:0] DESTINATION_REG,
   output logic [WORD_LEN-1:0]     DATA_IN
);
   import regfile_write_arbiter_pkg::*;

   localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

   arb_state_t              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic [REG_ADDR_LEN-1:0] dreg_q, dreg_d;
   logic [WORD_LEN-1:0]     din_q, din_d;
   logic                    a_rdy, b_rdy, a_xfer, b_xfer;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      a_rdy   = 1'b1;
      b_rdy   = !A_VALID;
      if (state_q == ARB_FORCE_B) begin
         a_rdy   = 1'b0;
         b_rdy   = 1'b1;
         // B either transfers now or has withdrawn; both end the forced grant
         state_d = ARB_NORMAL;
      end else if (B_VALID && A_VALID) begin
         if (cnt_q == CNT_LAST) state_d = ARB_FORCE_B;
         else                   cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   assign a_xfer = A_VALID && a_rdy;
   assign b_xfer = B_VALID && b_rdy;

   always_comb begin
      we_d   = 1'b0;
      dreg_d = '0;
      din_d  = '0;
      if (a_xfer && A_REG != '0) begin
         we_d   = 1'b1;
         dreg_d = A_REG;
         din_d  = A_DATA;
      end else if (b_xfer && B_REG != '0) begin
         we_d   = 1'b1;
         dreg_d = B_REG;
         din_d  = B_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ARB_NORMAL;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         dreg_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         dreg_q  <= dreg_d;
         din_q   <= din_d;
      end
   end

   regfile_write_arbiter_reg_scoreboard #(
      .REG_ADDR_LEN(REG_ADDR_LEN)
   ) u_scoreboard (
      .clk        (CLK),
      .rst        (RESET),
      .set_vld    (RSV_VALID),
      .set_reg    (RSV_REG),
      .clr_vld    (b_xfer),
      .clr_reg    (B_REG),
      .src1_reg   (SOURCE_REG1),
      .src2_reg   (SOURCE_REG2),
      .hazard1    (HAZARD1),
      .hazard2    (HAZARD2),
      .overlap_err(OVERLAP_ERR)
   );

   assign A_READY         = a_rdy;
   assign B_READY         = b_rdy;
   assign WRITE_ENABLE    = we_q;
   assign DESTINATION_REG = dreg_q;
   assign DATA_IN         = din_q;

endmodule
